irq_ctrl_n: RTL and testbench
=============================

IRQ_CTRL_N -- requirements
Module: irq_ctrl_n

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of interrupt request channels (2..16).
REQ-002 SHALL have parameter TMO, default 8, meaning service-timeout limit in clock cycles (2..255).
REQ-003 SHALL have port clock  input  1  meaning the single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port req  input  N_CH  meaning per-channel request pulses, each sampled every cycle.
REQ-006 SHALL have port eql  input  1  meaning service-complete indication from the serviced unit.
REQ-007 SHALL have port cont_eql  input  1  meaning continue/re-service request, sampled in DONE.
REQ-008 SHALL have port ackout  output  1  meaning grant acknowledge, one-cycle pulse.
REQ-009 SHALL have port grant_id  output  clog2(N_CH)  meaning index of the channel being serviced.
REQ-010 SHALL have port cc_mux  output  2  meaning datapath select code.
REQ-011 SHALL have port uscite  output  2  meaning service-exit code.
REQ-012 SHALL have port enable_count  output  1  meaning service counter active.
REQ-013 SHALL have port pending  output  N_CH  meaning latched unserviced requests.
REQ-014 SHALL have port timeout  output  1  meaning last service ended by timeout, sticky until next GRANT.

Function
REQ-015 SHALL set pending[i] on any cycle with req[i]=1; the set SHALL win over a same-cycle clear.
REQ-016 SHALL implement FSM states IDLE, GRANT, SERVICE, DONE; all outputs Moore, registered.
REQ-017 IDLE: cc_mux=00, uscite=00, ackout=0, enable_count=0; if pending!=0, latch arbiter winner into grant_id, go GRANT next cycle.
REQ-018 GRANT: ackout=1, cc_mux=01, clear timeout, clear counter; go SERVICE unconditionally (exactly one cycle).
REQ-019 SERVICE: enable_count=1, cc_mux=10, counter increments each cycle; eql=1 -> DONE with timeout=0; else counter==TMO-1 -> DONE with timeout=1; eql wins if both.
REQ-020 DONE: uscite=11 if timeout=0 else 10, cc_mux=11, clear pending[grant_id] (subject to REQ-015).
REQ-021 DONE: cont_eql=1 -> SERVICE with counter cleared and same grant_id; else IDLE.
REQ-022 Default arbitration SHALL be fixed priority, lowest index wins.
REQ-023 Minimum request-to-ackout latency SHALL be 2 cycles (req edge -> pending -> GRANT).
REQ-024 Counter width SHALL be clog2(TMO), no wrap: SERVICE exits at TMO-1.

Reset
REQ-025 reset SHALL force state IDLE, pending=0, grant_id=0, counter=0, timeout=0, all other outputs 0, on the next rising edge, from any state.
REQ-026 req asserted during the reset cycle SHALL NOT be latched.

Configuration
REQ-027 With IRQ_CTRL_RR_EN defined, arbitration SHALL be round-robin: search starts at (last grant_id+1) mod N_CH; last-grant pointer resets to N_CH-1.
REQ-028 Without IRQ_CTRL_RR_EN, arbitration SHALL be fixed priority per REQ-022 and no pointer register SHALL exist.

Structure
REQ-029 Shared package irq_ctrl_pkg SHALL hold the state enum and the cc_mux/uscite encoding constants.
REQ-030 Arbitration SHALL be a sub-module irq_arb (combinational winner select, optional RR pointer input).

Verification
REQ-031 req=0001 single pulse, eql=1 on 3rd SERVICE cycle -> ackout pulse 2 cycles after req, grant_id=0, uscite=11 one cycle, pending=0, back to IDLE.
REQ-032 req=1010 same cycle, fixed priority -> grant_id=1 then grant_id=3; with IRQ_CTRL_RR_EN after prior grant 1 -> grant_id=3 first.
REQ-033 TMO=8, eql held 0 -> SERVICE for 8 cycles, timeout=1, uscite=10.
REQ-034 cont_eql=1 in DONE -> returns to SERVICE, grant_id unchanged, no ackout, counter restarts at 0.
REQ-035 req[grant_id] pulsed in DONE cycle -> pending[grant_id] remains 1, channel regranted.
REQ-036 reset asserted mid-SERVICE with pending=0110 -> next cycle IDLE, pending=0, all outputs 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared types and encodings for the interrupt controller:
//                FSM state enum, cc_mux datapath select codes and uscite
//                service-exit codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Datapath select codes driven on cc_mux, one per state
    localparam logic [1:0] c_cc_idle    = 2'b00;
    localparam logic [1:0] c_cc_grant   = 2'b01;
    localparam logic [1:0] c_cc_service = 2'b10;
    localparam logic [1:0] c_cc_done    = 2'b11;

    // Service-exit codes driven on uscite
    localparam logic [1:0] c_usc_none   = 2'b00;
    localparam logic [1:0] c_usc_tmo    = 2'b10;
    localparam logic [1:0] c_usc_ok     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/irq_arb.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arb
//  Description : Combinational winner select over the pending vector.
//                Default: fixed priority, lowest index wins.
//                With IRQ_CTRL_RR_EN defined: round-robin, search starts at
//                (i_last + 1) mod N_CH.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_arb
    import irq_ctrl_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         i_req,
`ifdef IRQ_CTRL_RR_EN
    input  logic [$clog2(N_CH)-1:0] i_last,
`endif
    output logic [$clog2(N_CH)-1:0] o_win
);

    localparam int IW = $clog2(N_CH);

`ifdef IRQ_CTRL_RR_EN
    logic [IW-1:0] w_idx;

    // Scan from farthest to nearest so the channel just after i_last wins
    always_comb begin
        o_win = '0;
        w_idx = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = IW'((int'(i_last) + k) % N_CH);
            if (i_req[w_idx]) begin
                o_win = w_idx;
            end
        end
    end
`else
    // Scan from highest to lowest index so the lowest requesting index wins
    always_comb begin
        o_win = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_win = IW'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/irq_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_n
//  Description : N-channel interrupt controller. Latches request pulses into
//                a pending vector, grants one channel at a time and tracks
//                its service with a timeout counter. All outputs are Moore
//                and registered.
//                Optional macro IRQ_CTRL_RR_EN selects round-robin
//                arbitration instead of fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_n
    import irq_ctrl_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int TMO  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req,
    input  logic                    eql,
    input  logic                    cont_eql,
    output logic                    ackout,
    output logic [$clog2(N_CH)-1:0] grant_id,
    output logic [1:0]              cc_mux,
    output logic [1:0]              uscite,
    output logic                    enable_count,
    output logic [N_CH-1:0]         pending,
    output logic                    timeout
);

    localparam int            IW         = $clog2(N_CH);
    localparam int            CW         = $clog2(TMO);
    localparam logic [CW-1:0] c_cnt_last = CW'(TMO - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] w_clr;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   w_win;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            r_ackout;
    logic            r_en;
    logic [1:0]      r_cc_mux;
    logic [1:0]      r_uscite;
    logic [1:0]      w_cc_nxt;
    logic [1:0]      w_usc_nxt;

`ifdef IRQ_CTRL_RR_EN
    logic [IW-1:0] r_last;

    // Remember the last granted channel; reset value makes channel 0 first
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= IW'(N_CH - 1);
        end else if (r_state == IDLE && |r_pending) begin
            r_last <= w_win;
        end
    end

    irq_arb #(.N_CH(N_CH)) u_arb (
        .i_req  (r_pending),
        .i_last (r_last),
        .o_win  (w_win)
    );
`else
    irq_arb #(.N_CH(N_CH)) u_arb (
        .i_req  (r_pending),
        .o_win  (w_win)
    );
`endif

    // The serviced channel's pending bit is dropped on the way out of DONE
    assign w_clr = (r_state == DONE) ? ({{(N_CH-1){1'b0}}, 1'b1} << r_grant_id) : '0;

    // Next-state, timeout flag and next Moore output codes
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_nxt = r_timeout;
        w_cc_nxt      = c_cc_idle;
        w_usc_nxt     = c_usc_none;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_state_nxt   = GRANT;
                    // Cleared as GRANT starts so it already reads 0 there
                    w_timeout_nxt = 1'b0;
                end
            end
            GRANT: begin
                w_state_nxt = SERVICE;
            end
            SERVICE: begin
                if (eql) begin
                    w_state_nxt   = DONE;
                    w_timeout_nxt = 1'b0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt   = DONE;
                    w_timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = cont_eql ? SERVICE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        case (w_state_nxt)
            GRANT:   w_cc_nxt = c_cc_grant;
            SERVICE: w_cc_nxt = c_cc_service;
            DONE: begin
                w_cc_nxt  = c_cc_done;
                w_usc_nxt = w_timeout_nxt ? c_usc_tmo : c_usc_ok;
            end
            default: w_cc_nxt = c_cc_idle;
        endcase
    end

    // State, pending vector, counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            r_ackout   <= 1'b0;
            r_en       <= 1'b0;
            r_cc_mux   <= c_cc_idle;
            r_uscite   <= c_usc_none;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_timeout_nxt;
            r_ackout  <= (w_state_nxt == GRANT);
            r_en      <= (w_state_nxt == SERVICE);
            r_cc_mux  <= w_cc_nxt;
            r_uscite  <= w_usc_nxt;
            // A new request wins over the DONE clear of the same bit
            r_pending <= (r_pending & ~w_clr) | req;
            if (r_state == IDLE && |r_pending) begin
                r_grant_id <= w_win;
            end
            // Counts only while staying in SERVICE; any entry starts at 0
            if (r_state == SERVICE && w_state_nxt == SERVICE) begin
                r_cnt <= r_cnt + c_cnt_one;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign ackout       = r_ackout;
    assign grant_id     = r_grant_id;
    assign cc_mux       = r_cc_mux;
    assign uscite       = r_uscite;
    assign enable_count = r_en;
    assign pending      = r_pending;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl_n
//  Description : Self-checking bench for irq_ctrl_n (N_CH=4, TMO=8).
//                Expected service completions are queued when a grant is
//                observed and popped when the DUT reaches DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl_n;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       eql;
    logic       cont_eql;
    logic       ackout;
    logic [1:0] grant_id;
    logic [1:0] cc_mux;
    logic [1:0] uscite;
    logic       enable_count;
    logic [3:0] pending;
    logic       timeout;

    typedef struct packed {
        logic [1:0] gid;
        logic [1:0] usc;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] first_gid;
    logic [1:0] second_gid;

    irq_ctrl_n #(.N_CH(4), .TMO(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .ackout       (ackout),
        .grant_id     (grant_id),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .pending      (pending),
        .timeout      (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] gid, input logic [1:0] usc, input logic tmo);
        exp_t e;
        e.gid = gid;
        e.usc = usc;
        e.tmo = tmo;
        return e;
    endfunction

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From a GRANT cycle: eql on the first SERVICE cycle, ends in the cycle after DONE
    task automatic svc_fast();
        tick();
        eql = 1'b1;
        tick();
        eql = 1'b0;
        tick();
    endtask

    // Scoreboard: every DONE cycle must match the oldest queued expectation
    always @(negedge clock) begin
        if (!reset && cc_mux == 2'b11) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("done_gid", 32'(grant_id), 32'(m_e.gid));
                check("done_uscite", 32'(uscite), 32'(m_e.usc));
                check("done_timeout", 32'(timeout), 32'(m_e.tmo));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = 4'b1111;
        eql      = 1'b0;
        cont_eql = 1'b0;
        tick();
        tick();
        check("rst_ackout", 32'(ackout), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_ccmux", 32'(cc_mux), 32'd0);
        check("rst_uscite", 32'(uscite), 32'd0);
        check("rst_en", 32'(enable_count), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        req   = 4'b0000;
        reset = 1'b0;
        tick();

        // Single request, eql on the third SERVICE cycle
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("s1_pending", 32'(pending), 32'h1);
        check("s1_ack_early", 32'(ackout), 32'd0);
        tick();
        check("s1_ack", 32'(ackout), 32'd1);
        check("s1_gid", 32'(grant_id), 32'd0);
        check("s1_cc_grant", 32'(cc_mux), 32'h1);
        sb.push_back(mk(2'd0, 2'b11, 1'b0));
        tick();
        check("s1_ack_pulse", 32'(ackout), 32'd0);
        check("s1_en", 32'(enable_count), 32'd1);
        check("s1_cc_service", 32'(cc_mux), 32'h2);
        tick();
        tick();
        eql = 1'b1;
        tick();
        eql = 1'b0;
        check("s1_cc_done", 32'(cc_mux), 32'h3);
        check("s1_uscite", 32'(uscite), 32'h3);
        tick();
        check("s1_idle_cc", 32'(cc_mux), 32'h0);
        check("s1_idle_usc", 32'(uscite), 32'h0);
        check("s1_idle_pend", 32'(pending), 32'h0);

        // Prior grant to channel 1, then requests 1 and 3 together
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        check("s2_prior_gid", 32'(grant_id), 32'd1);
        sb.push_back(mk(2'd1, 2'b11, 1'b0));
        svc_fast();
`ifdef IRQ_CTRL_RR_EN
        first_gid  = 2'd3;
        second_gid = 2'd1;
`else
        first_gid  = 2'd1;
        second_gid = 2'd3;
`endif
        req = 4'b1010;
        tick();
        req = 4'b0000;
        check("s2_pending", 32'(pending), 32'ha);
        tick();
        check("s2_gid_first", 32'(grant_id), 32'(first_gid));
        sb.push_back(mk(first_gid, 2'b11, 1'b0));
        svc_fast();
        tick();
        check("s2_ack_second", 32'(ackout), 32'd1);
        check("s2_gid_second", 32'(grant_id), 32'(second_gid));
        sb.push_back(mk(second_gid, 2'b11, 1'b0));
        svc_fast();
        check("s2_pend_clear", 32'(pending), 32'h0);

        // Timeout: eql held low for the whole service
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        sb.push_back(mk(2'd2, 2'b10, 1'b1));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("s3_en", 32'(enable_count), 32'd1);
        end
        tick();
        check("s3_cc_done", 32'(cc_mux), 32'h3);
        check("s3_uscite", 32'(uscite), 32'h2);
        tick();
        check("s3_tmo_sticky", 32'(timeout), 32'd1);

        // Continue: first service ends by eql, then re-service times out
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        check("s4_tmo_clr", 32'(timeout), 32'd0);
        sb.push_back(mk(2'd0, 2'b11, 1'b0));
        tick();
        tick();
        tick();
        eql = 1'b1;
        tick();
        eql      = 1'b0;
        cont_eql = 1'b1;
        sb.push_back(mk(2'd0, 2'b10, 1'b1));
        tick();
        cont_eql = 1'b0;
        check("s4_no_ack", 32'(ackout), 32'd0);
        check("s4_cc_service", 32'(cc_mux), 32'h2);
        check("s4_gid", 32'(grant_id), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("s4_en", 32'(enable_count), 32'd1);
        end
        tick();
        check("s4_cc_done", 32'(cc_mux), 32'h3);
        tick();

        // Request on the serviced channel during DONE keeps it pending
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        check("s5_gid", 32'(grant_id), 32'd3);
        sb.push_back(mk(2'd3, 2'b11, 1'b0));
        tick();
        eql = 1'b1;
        tick();
        eql = 1'b0;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check("s5_pend_kept", 32'(pending), 32'h8);
        tick();
        check("s5_regrant_ack", 32'(ackout), 32'd1);
        check("s5_regrant_gid", 32'(grant_id), 32'd3);
        sb.push_back(mk(2'd3, 2'b11, 1'b0));
        svc_fast();
        check("s5_pend_clear", 32'(pending), 32'h0);

        // Reset in the middle of SERVICE with two channels pending
        req = 4'b0010;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        check("s6_pending", 32'(pending), 32'h6);
        check("s6_en", 32'(enable_count), 32'd1);
        reset = 1'b1;
        req   = 4'b0001;
        tick();
        reset = 1'b0;
        req   = 4'b0000;
        check("s6_pending_rst", 32'(pending), 32'h0);
        check("s6_cc_rst", 32'(cc_mux), 32'h0);
        check("s6_en_rst", 32'(enable_count), 32'd0);
        check("s6_gid_rst", 32'(grant_id), 32'd0);
        check("s6_usc_rst", 32'(uscite), 32'h0);
        tick();
        tick();
        check("s6_no_latch", 32'(pending), 32'h0);
        check("s6_no_ack", 32'(ackout), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
